// File: rtl/nibble_logic_sequencer_pkg.sv
// Shared definitions for the nibble logic sequencer: operation codes,
// FSM state encodings and default geometry.
package nibble_logic_sequencer_pkg;

  // Logic operation applied by the shared slice
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SLICE_W = 4;

  // Index counter width; never below one bit so the counter always exists
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_logic_sequencer_if.sv
// Operand/result bus of the nibble logic sequencer.
// NIBBLE_SEQ_ZERO_FLAG_EN adds the zero result flag to the bus.
interface nibble_logic_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
  logic             zero;

  modport master (output start, op, a, b, input busy, done, out, zero);
  modport slave  (input start, op, a, b, output busy, done, out, zero);
`else
  modport master (output start, op, a, b, input busy, done, out);
  modport slave  (input start, op, a, b, output busy, done, out);
`endif
endinterface

// File: rtl/nibble_logic_sequencer_slice.sv
// Combinational SLICE_W-bit logic unit shared across all operand nibbles.
module nibble_logic_slice
  import nibble_logic_sequencer_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [1:0]         i_op,
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  output logic [SLICE_W-1:0] o_out
);

  // Pure bitwise selection; no carries between bits or slices
  always_comb begin
    o_out = '0;
    case (i_op)
      OP_AND:  o_out = i_a & i_b;
      OP_OR:   o_out = i_a | i_b;
      OP_XOR:  o_out = i_a ^ i_b;
      OP_NOR:  o_out = ~(i_a | i_b);
      default: o_out = '0;
    endcase
  end

endmodule

// File: rtl/nibble_logic_sequencer.sv
// Multi-cycle bitwise logic unit: latches operands on start and pushes one
// nibble per clock through a single shared slice, LSB nibble first.
// Optional: define NIBBLE_SEQ_ZERO_FLAG_EN to add the zero result flag.
module nibble_logic_sequencer
  import nibble_logic_sequencer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  nibble_logic_sequencer_if.slave   bus
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [1:0]         r_op;
  logic [SLICE_W-1:0] r_a_nib   [NIBBLES];
  logic [SLICE_W-1:0] r_b_nib   [NIBBLES];
  logic [SLICE_W-1:0] r_out_nib [NIBBLES];
  logic [SLICE_W-1:0] w_slice;
  logic               w_accept;
  logic               w_last;
  logic               w_busy;
  logic               w_done;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_idx == LAST_IDX);

  nibble_logic_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .i_op  (r_op),
    .i_a   (r_a_nib[r_idx]),
    .i_b   (r_b_nib[r_idx]),
    .o_out (w_slice)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state and status decode
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_RUN;
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;

  // Nibble index: cleared on accept, advances during RUN, stops at the last nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
    end else if (r_state == S_RUN && !w_last) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Operand latches and per-nibble result writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= '0;
      for (int i = 0; i < NIBBLES; i++) begin
        r_a_nib[i]   <= '0;
        r_b_nib[i]   <= '0;
        r_out_nib[i] <= '0;
      end
    end else if (w_accept) begin
      r_op <= bus.op;
      for (int i = 0; i < NIBBLES; i++) begin
        r_a_nib[i]   <= bus.a[i*SLICE_W +: SLICE_W];
        r_b_nib[i]   <= bus.b[i*SLICE_W +: SLICE_W];
        r_out_nib[i] <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_out_nib[r_idx] <= w_slice;
    end
  end

  // Pack the nibble result registers onto the output bus
  for (genvar g = 0; g < NIBBLES; g++) begin : g_pack
    assign bus.out[g*SLICE_W +: SLICE_W] = r_out_nib[g];
  end

`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
  logic r_acc;
  logic r_zero;

  // Zero flag from an OR accumulated over written nibbles, resolved on the last one
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_acc  <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_acc <= r_acc | (|w_slice);
      if (w_last) r_zero <= ~(r_acc | (|w_slice));
    end
  end

  assign bus.zero = r_zero;
`endif

endmodule

// File: tb/tb_nibble_logic_sequencer.sv
// Directed bench for nibble_logic_sequencer: a vector table of single
// operations plus hand-written sequences for held start and mid-run reset.
`timescale 1ns/1ps
module tb_nibble_logic_sequencer;
  import nibble_logic_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  nibble_logic_sequencer_if #(.WIDTH(32)) bus ();

  nibble_logic_sequencer #(
    .WIDTH   (32),
    .SLICE_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a falling edge with the unit idle; returns one cycle
  // after the done pulse, again idle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input string name);
    logic busy_ok;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    check({name, " busy after accept"}, {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.op    = ~op;
    busy_ok   = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (!(bus.busy === 1'b1 && bus.done === 1'b0)) busy_ok = 1'b0;
    end
    check({name, " busy 8 cycles"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    check({name, " done pulse"}, {30'd0, bus.busy, bus.done}, 32'd1);
    check({name, " result"}, bus.out, exp);
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
    check({name, " zero flag"}, {31'd0, bus.zero}, {31'd0, (exp == 32'd0)});
`endif
    @(negedge clk);
    check({name, " done low after"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check({name, " result held"}, bus.out, exp);
  endtask

  initial begin
    logic seen_done;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0] = '{OP_AND, 32'hF0F0_1234, 32'hFF00_FF0F, 32'hF000_1204, "and"};
    vecs[1] = '{OP_OR,  32'h0000_00FF, 32'h1200_0000, 32'h1200_00FF, "or"};
    vecs[2] = '{OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, "xor"};
    vecs[3] = '{OP_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, "nor"};
    vecs[4] = '{OP_NOR, 32'h0F00_A5C3, 32'h1020_0A03, 32'hE0DF_503C, "nor mixed"};
    vecs[5] = '{OP_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, "and zero"};
    vecs[6] = '{OP_OR,  32'h0000_0000, 32'h8000_0000, 32'h8000_0000, "or msb"};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset out", bus.out, 32'd0);
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
    check("reset zero", {31'd0, bus.zero}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // start held high with operands churning through RUN and DONE
    bus.start = 1'b1;
    bus.op    = OP_AND;
    bus.a     = 32'hFFFF_0000;
    bus.b     = 32'h0F0F_0F0F;
    @(negedge clk);
    check("held busy", {31'd0, bus.busy}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      bus.op = 2'($urandom_range(0, 3));
      bus.a  = $urandom;
      bus.b  = $urandom;
      @(negedge clk);
    end
    check("held done", {30'd0, bus.busy, bus.done}, 32'd1);
    check("held result", bus.out, 32'h0F0F_0000);
    bus.op = OP_XOR;
    bus.a  = 32'h1234_5678;
    bus.b  = 32'hFFFF_FFFF;
    @(negedge clk);
    check("held idle gap", {30'd0, bus.busy, bus.done}, 32'd0);
    check("held out kept", bus.out, 32'h0F0F_0000);
    @(negedge clk);
    check("held reaccept busy", {31'd0, bus.busy}, 32'd1);
    check("held reaccept clears", bus.out, 32'd0);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk);
    check("held second done", {30'd0, bus.busy, bus.done}, 32'd1);
    check("held second result", bus.out, 32'hEDCB_A987);
    @(negedge clk);

    // reset during the 4th RUN cycle
    bus.start = 1'b1;
    bus.op    = OP_AND;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
    check("midrst out", bus.out, 32'd0);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done = 1'b1;
    end
    check("midrst no done", {31'd0, seen_done}, 32'd0);
    run_op(OP_AND, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, "after rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
